fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 91 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared defaults, state encoding and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned BURST_DEF  = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping modulo N_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned IdxW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  last_owner,
  output logic             valid,
  output logic [IdxW-1:0]  index
);

  int unsigned cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_owner) + i) % N_REQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Grants the shared FIFO write port to one producer at a time in bursts of up to BURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BURST  = BURST_DEF,
  localparam int unsigned IdxW  = idx_width(N_REQ),
  localparam int unsigned CntW  = idx_width(BURST)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  input  logic                      fifo_full,
  output logic [IdxW-1:0]           owner_id,
  output logic                      busy
);

  arb_state_e      state;
  logic [IdxW-1:0] owner;
  logic [IdxW-1:0] last_owner;
  logic [CntW-1:0] beat_cnt;

  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic            accept;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req       (req),
    .last_owner(last_owner),
    .valid     (pick_valid),
    .index     (pick_idx)
  );

  // Outputs are masked while reset is high so a burst in flight cannot write during reset.
  assign accept = (state == StBusy) && req[owner] && !fifo_full && !reset;

  always_comb begin
    grant        = '0;
    fifo_data_in = '0;
    if (accept) begin
      grant[owner] = 1'b1;
      fifo_data_in = req_data[int'(owner)*DATA_W +: DATA_W];
    end
  end

  assign fifo_wr_en = accept;
  assign busy       = (state == StBusy) && !reset;
  assign owner_id   = reset ? '0 : owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      owner      <= '0;
      beat_cnt   <= '0;
      last_owner <= IdxW'(N_REQ - 1);
    end else begin
      unique case (state)
        StIdle: begin
          if (pick_valid && !fifo_full) begin
            state    <= StBusy;
            owner    <= pick_idx;
            beat_cnt <= '0;
          end
        end
        StBusy: begin
          if (!req[owner]) begin
            state      <= StIdle;
            last_owner <= owner;
          end else if (accept) begin
            if (beat_cnt == CntW'(BURST - 1)) begin
              state      <= StIdle;
              last_owner <= owner;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          // req held while full: stall with state, owner and beat_cnt unchanged
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks for fifo_wr_arbiter with N_REQ=4, DATA_W=8, BURST=4.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic        fifo_full;
  logic [1:0]  owner_id;
  logic        busy;

  int checks;
  int failures;

  fifo_wr_arbiter #(
    .N_REQ (4),
    .DATA_W(8),
    .BURST (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .fifo_full   (fifo_full),
    .owner_id    (owner_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; req_data = 32'hD3D2D1D0; fifo_full = 1'b0;
    tick(); tick(); settle();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", fifo_wr_en); end
    checks++; if (fifo_data_in !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", fifo_data_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (owner_id !== 2'd0) begin failures++; $display("FAIL rst_owner got=%0d exp=0", owner_id); end
    tick(); reset = 1'b0; settle();
    checks++; if (busy !== 1'b0 || grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      failures++; $display("FAIL rst_after got busy=%b grant=%b wr=%b exp 0/0000/0", busy, grant, fifo_wr_en);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0001; req_data = 32'h000000A5; settle();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL single_bubble got grant=%b busy=%b exp 0000/0", grant, busy);
    end
    tick(); settle();
    checks++; if (grant !== 4'b0001 || fifo_wr_en !== 1'b1 || fifo_data_in !== 8'hA5) begin
      failures++; $display("FAIL single_w0 got grant=%b wr=%b data=%h exp 0001/1/a5", grant, fifo_wr_en, fifo_data_in);
    end
    checks++; if (owner_id !== 2'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_owner got owner=%0d busy=%b exp 0/1", owner_id, busy);
    end
    tick(); req_data[7:0] = 8'h3C; settle();
    checks++; if (grant !== 4'b0001 || fifo_data_in !== 8'h3C) begin
      failures++; $display("FAIL single_w1 got grant=%b data=%h exp 0001/3c", grant, fifo_data_in);
    end
    tick(); req_data[7:0] = 8'hFF; settle();
    checks++; if (grant !== 4'b0001 || fifo_data_in !== 8'hFF) begin
      failures++; $display("FAIL single_w2 got grant=%b data=%h exp 0001/ff", grant, fifo_data_in);
    end
    tick(); req = 4'b0000; settle();
    checks++; if (fifo_wr_en !== 1'b0 || fifo_data_in !== 8'h00 || busy !== 1'b1) begin
      failures++; $display("FAIL single_drop got wr=%b data=%h busy=%b exp 0/00/1", fifo_wr_en, fifo_data_in, busy);
    end
    tick(); settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    int         e;
    do_reset();
    req = 4'b1111; req_data = 32'hD3D2D1D0; settle();
    for (int b = 0; b < 5; b++) begin
      e = b % 4;
      exp_g = 4'b0001 << e;
      exp_d = 8'hD0 + 8'(e);
      checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin
        failures++; $display("FAIL rr_bubble%0d got busy=%b grant=%b exp 0/0000", b, busy, grant);
      end
      tick(); settle();
      for (int k = 0; k < 4; k++) begin
        checks++; if (grant !== exp_g || owner_id !== 2'(e) || fifo_data_in !== exp_d) begin
          failures++;
          $display("FAIL rr_b%0d_k%0d got grant=%b owner=%0d data=%h exp %b/%0d/%h",
                   b, k, grant, owner_id, fifo_data_in, exp_g, e, exp_d);
        end
        tick(); settle();
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_full_stall();
    int writes;
    writes = 0;
    do_reset();
    req = 4'b0100; req_data = 32'h002A0000; fifo_full = 1'b0; settle();
    tick(); settle();
    checks++; if (grant !== 4'b0100 || fifo_wr_en !== 1'b1) begin
      failures++; $display("FAIL stall_b0 got grant=%b wr=%b exp 0100/1", grant, fifo_wr_en);
    end
    if (fifo_wr_en) writes++;
    tick(); fifo_full = 1'b1; settle();
    for (int c = 0; c < 3; c++) begin
      checks++; if (fifo_wr_en !== 1'b0 || grant !== 4'b0000 || owner_id !== 2'd2 || busy !== 1'b1
                    || fifo_data_in !== 8'h00) begin
        failures++;
        $display("FAIL stall_c%0d got wr=%b grant=%b owner=%0d busy=%b data=%h exp 0/0000/2/1/00",
                 c, fifo_wr_en, grant, owner_id, busy, fifo_data_in);
      end
      tick(); settle();
    end
    fifo_full = 1'b0; settle();
    for (int k = 1; k < 4; k++) begin
      checks++; if (grant !== 4'b0100 || fifo_data_in !== 8'h2A) begin
        failures++; $display("FAIL stall_resume%0d got grant=%b data=%h exp 0100/2a", k, grant, fifo_data_in);
      end
      if (fifo_wr_en) writes++;
      tick(); settle();
    end
    checks++; if (writes !== 4 || busy !== 1'b0) begin
      failures++; $display("FAIL stall_total got writes=%0d busy=%b exp 4/0", writes, busy);
    end
  endtask

  task automatic test_idle_full();
    req = 4'b0100; fifo_full = 1'b1; settle();
    for (int c = 0; c < 3; c++) begin
      checks++; if (busy !== 1'b0 || grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
        failures++; $display("FAIL idlefull_c%0d got busy=%b grant=%b wr=%b exp 0/0000/0", c, busy, grant, fifo_wr_en);
      end
      tick(); settle();
    end
    fifo_full = 1'b0; settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idlefull_bubble got busy=%b exp=0", busy); end
    tick(); settle();
    checks++; if (busy !== 1'b1 || owner_id !== 2'd2 || grant !== 4'b0100) begin
      failures++; $display("FAIL idlefull_grant got busy=%b owner=%0d grant=%b exp 1/2/0100", busy, owner_id, grant);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010; req_data = 32'h00007700; settle();
    tick(); tick(); tick(); settle();
    checks++; if (grant !== 4'b0010 || fifo_data_in !== 8'h77) begin
      failures++; $display("FAIL rstmid_b2 got grant=%b data=%h exp 0010/77", grant, fifo_data_in);
    end
    reset = 1'b1; settle();
    checks++; if (fifo_wr_en !== 1'b0 || grant !== 4'b0000) begin
      failures++; $display("FAIL rstmid_inrst got wr=%b grant=%b exp 0/0000", fifo_wr_en, grant);
    end
    tick(); reset = 1'b0; req = 4'b0011; settle();
    checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || grant !== 4'b0000) begin
      failures++; $display("FAIL rstmid_after got busy=%b wr=%b grant=%b exp 0/0/0000", busy, fifo_wr_en, grant);
    end
    tick(); settle();
    checks++; if (busy !== 1'b1 || owner_id !== 2'd0 || grant !== 4'b0001) begin
      failures++; $display("FAIL rstmid_first got busy=%b owner=%0d grant=%b exp 1/0/0001", busy, owner_id, grant);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_random();
    int         waits [4];
    logic [3:0] gprev;
    logic [7:0] exp_d;
    int         bound;
    bound = 4 * (4 + 1);
    gprev = 4'b0000;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    do_reset();
    req = 4'b0000; fifo_full = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (gprev[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          req_data[i*8 +: 8] = 8'($urandom);
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      settle();
      gprev = grant;
      exp_d = 8'h00;
      for (int i = 0; i < 4; i++) if (grant[i]) exp_d = req_data[i*8 +: 8];
      checks++; if (!$onehot0(grant) || fifo_wr_en !== (|grant)) begin
        failures++; $display("FAIL rand_grant cyc=%0d got grant=%b wr=%b exp one-hot-or-zero matching wr", cyc, grant, fifo_wr_en);
      end
      checks++; if (fifo_wr_en && fifo_full) begin
        failures++; $display("FAIL rand_full cyc=%0d got wr=%b full=%b exp no write while full", cyc, fifo_wr_en, fifo_full);
      end
      checks++; if (fifo_data_in !== exp_d) begin
        failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, fifo_data_in, exp_d);
      end
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) waits[i] = 0;
        else if (req[i] && !fifo_full) waits[i]++;
      end
      checks++; if (waits[0] > bound || waits[1] > bound || waits[2] > bound || waits[3] > bound) begin
        failures++;
        $display("FAIL rand_starve cyc=%0d got waits=%0d,%0d,%0d,%0d exp each <= %0d",
                 cyc, waits[0], waits[1], waits[2], waits[3], bound);
        for (int i = 0; i < 4; i++) waits[i] = 0;
      end
    end
    req = 4'b0000; fifo_full = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_idle_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
